// File: rtl/burst_rd_mem_responder.sv
// -----------------------------------------------------------------------------
// burst_rd_mem_responder
//
// Memory-side responder for the 32-byte-aligned burst read protocol used by
// the instruction cache refill path. One request is accepted at a time. Each
// request returns a fixed 8-beat burst of 32-bit words from an internal word
// array. The final beat is marked with to_cache_rd_rsp_last. Both channels use
// valid/ready handshakes.
//
// Parameters
//   MEM_ADDR_W  log2 of array depth in 32-bit words (default 10 = 4 KiB)
//   RD_LAT      idle cycles between request acceptance and first beat (0..15)
//   BURST_LEN   beats per burst, fixed at 8 by the protocol
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   from_cache_rd_req_valid  request valid
//   from_cache_rd_req_addr   request byte address (bits [4:0] ignored,
//                            bits above MEM_ADDR_W+1 alias)
//   to_cache_rd_req_ready    responder can accept a request (registered)
//   to_cache_rd_rsp_valid    response beat valid (registered)
//   to_cache_rd_rsp_data     response beat data (registered)
//   to_cache_rd_rsp_last     current beat is the 8th of the burst (registered)
//   from_cache_rd_rsp_ready  requester accepts current beat
//   init_wr_en/addr/data     preload write port, usable in any state
//
// Optional feature (macro BURST_RSP_RANDOM_STALL_EN)
//   When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) advances
//   every cycle. After each non-last beat handshake where lfsr[0]==1, exactly
//   one bubble cycle (valid low) is inserted before the next beat.
// -----------------------------------------------------------------------------
module burst_rd_mem_responder #(
  parameter int MEM_ADDR_W = 10,
  parameter int RD_LAT     = 2,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  from_cache_rd_req_valid,
  input  logic [31:0]           from_cache_rd_req_addr,
  output logic                  to_cache_rd_req_ready,
  output logic                  to_cache_rd_rsp_valid,
  output logic [31:0]           to_cache_rd_rsp_data,
  output logic                  to_cache_rd_rsp_last,
  input  logic                  from_cache_rd_rsp_ready,
  input  logic                  init_wr_en,
  input  logic [MEM_ADDR_W-1:0] init_wr_addr,
  input  logic [31:0]           init_wr_data
);

  localparam int         DEPTH     = 1 << MEM_ADDR_W;
  localparam int         LINE_W    = MEM_ADDR_W - 3;
  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t             state;
  logic [31:0]        mem [0:DEPTH-1];
  logic [LINE_W-1:0]  line_idx;   // line-aligned base: word index = {line_idx, beat}
  logic [2:0]         beat;       // beat currently presented (or next to load)
  logic [3:0]         lat_cnt;
  logic               stall_pick;

  logic [MEM_ADDR_W-1:0] rd_idx;
  logic [MEM_ADDR_W-1:0] rd_idx_next;

  // The 3-bit beat index wraps inside the line, so the word never leaves it.
  assign rd_idx      = {line_idx, beat};
  assign rd_idx_next = {line_idx, beat + 3'd1};

  // Offset bits and aliasing high bits do not take part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{from_cache_rd_req_addr[31:MEM_ADDR_W+2],
                              from_cache_rd_req_addr[4:0]};

`ifdef BURST_RSP_RANDOM_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall_pick = lfsr[0];
`else
  assign stall_pick = 1'b0;
`endif

  // NOTE: the word array is deliberately left out of reset; it is plain
  // storage loaded through the init port and maps onto RAM/ROM macros.
  always_ff @(posedge clk) begin
    if (init_wr_en) mem[init_wr_addr] <= init_wr_data;
  end

  // NOTE: all state and outputs update with non-blocking assignments, so the
  // array read below sees the pre-edge contents and a same-cycle init write to
  // the word being loaded returns the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      to_cache_rd_req_ready <= 1'b0;
      to_cache_rd_rsp_valid <= 1'b0;
      to_cache_rd_rsp_last  <= 1'b0;
      to_cache_rd_rsp_data  <= '0;
      line_idx              <= '0;
      beat                  <= '0;
      lat_cnt               <= '0;
    end else begin
      case (state)
        IDLE: begin
          to_cache_rd_req_ready <= 1'b1;
          if (from_cache_rd_req_valid && to_cache_rd_req_ready) begin
            line_idx              <= from_cache_rd_req_addr[MEM_ADDR_W+1:5];
            beat                  <= '0;
            lat_cnt               <= '0;
            to_cache_rd_req_ready <= 1'b0;
            state                 <= (RD_LAT > 0) ? WAIT : SEND;
          end
        end

        WAIT: begin
          if (lat_cnt == 4'(RD_LAT - 1)) state   <= SEND;
          else                           lat_cnt <= lat_cnt + 4'd1;
        end

        SEND: begin
          if (!to_cache_rd_rsp_valid) begin
            // Output register empty (burst start or after a bubble): load it.
            to_cache_rd_rsp_valid <= 1'b1;
            to_cache_rd_rsp_data  <= mem[rd_idx];
            to_cache_rd_rsp_last  <= (beat == LAST_BEAT);
          end else if (from_cache_rd_rsp_ready) begin
            if (to_cache_rd_rsp_last) begin
              to_cache_rd_rsp_valid <= 1'b0;
              to_cache_rd_rsp_last  <= 1'b0;
              to_cache_rd_req_ready <= 1'b1;
              state                 <= IDLE;
            end else begin
              beat <= beat + 3'd1;
              if (stall_pick) begin
                // One bubble; the empty-register branch loads the beat next.
                to_cache_rd_rsp_valid <= 1'b0;
                to_cache_rd_rsp_last  <= 1'b0;
              end else begin
                to_cache_rd_rsp_data <= mem[rd_idx_next];
                to_cache_rd_rsp_last <= (beat + 3'd1 == LAST_BEAT);
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_rd_mem_responder.sv
// -----------------------------------------------------------------------------
// Testbench for burst_rd_mem_responder (default parameters: MEM_ADDR_W=10,
// RD_LAT=2). Expected data comes from a shadow copy of the word array and the
// rule "beat i of a request to byte address A returns word ((A/32)*8+i) mod
// depth". Expected timing comes from the acceptance cycle plus RD_LAT.
// Inputs change and outputs are sampled on the falling clock edge. Cycle k is
// the period that starts at rising edge k. A handshake seen in cycle k takes
// effect at rising edge k+1.
// -----------------------------------------------------------------------------
module tb_burst_rd_mem_responder;

  localparam int MEM_ADDR_W = 10;
  localparam int RD_LAT     = 2;
  localparam int DEPTH      = 1 << MEM_ADDR_W;
`ifdef BURST_RSP_RANDOM_STALL_EN
  localparam int MAX_GAP = 1;
`else
  localparam int MAX_GAP = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  from_cache_rd_req_valid;
  logic [31:0]           from_cache_rd_req_addr;
  logic                  to_cache_rd_req_ready;
  logic                  to_cache_rd_rsp_valid;
  logic [31:0]           to_cache_rd_rsp_data;
  logic                  to_cache_rd_rsp_last;
  logic                  from_cache_rd_rsp_ready;
  logic                  init_wr_en;
  logic [MEM_ADDR_W-1:0] init_wr_addr;
  logic [31:0]           init_wr_data;

  burst_rd_mem_responder #(
    .MEM_ADDR_W(MEM_ADDR_W),
    .RD_LAT    (RD_LAT),
    .BURST_LEN (8)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .from_cache_rd_req_valid(from_cache_rd_req_valid),
    .from_cache_rd_req_addr (from_cache_rd_req_addr),
    .to_cache_rd_req_ready  (to_cache_rd_req_ready),
    .to_cache_rd_rsp_valid  (to_cache_rd_rsp_valid),
    .to_cache_rd_rsp_data   (to_cache_rd_rsp_data),
    .to_cache_rd_rsp_last   (to_cache_rd_rsp_last),
    .from_cache_rd_rsp_ready(from_cache_rd_rsp_ready),
    .init_wr_en             (init_wr_en),
    .init_wr_addr           (init_wr_addr),
    .init_wr_data           (init_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // Shadow copy of the word array.
  logic [31:0] model_mem [DEPTH];

  // Results of the most recent burst.
  logic [31:0] b_data  [8];
  logic        b_last  [8];
  int          b_first [8];  // first cycle the beat was seen valid
  int          b_hs    [8];  // cycle in which the beat handshake was seen
  int          b_count;
  int          t_acc;        // rising edge at which the request was accepted
  int          hold_errs;
  int          rdy_errs;

  function automatic logic [31:0] exp_word(input logic [31:0] addr, input int i);
    longint unsigned w;
    w = ((longint'(addr) / 32) * 8 + i) % DEPTH;
    return model_mem[int'(w)];
  endfunction

  // Must be entered on a falling edge. Returns on the falling edge that
  // follows the rising edge of the stop_after-th beat handshake.
  // bp_mode: 0 = always ready, 1 = three stall cycles on beat 3, 2 = random.
  task automatic do_burst(input logic [31:0] addr, input int bp_mode,
                          input int stop_after, input bit hold_next,
                          input logic [31:0] next_addr, output bit ok);
    int          n;
    int          bp_left;
    bit          pend;
    bit          seen;
    logic [31:0] pd;
    logic        pl;
    ok = 1'b1;
    from_cache_rd_req_valid = 1'b1;
    from_cache_rd_req_addr  = addr;
    from_cache_rd_rsp_ready = 1'b0;
    n = 0;
    while (to_cache_rd_req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL accept_timeout: ready=%b after %0d cycles, required 1", to_cache_rd_req_ready, n);
      from_cache_rd_req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    t_acc = cyc + 1;
    @(negedge clk);
    if (hold_next) from_cache_rd_req_addr = next_addr;
    else begin
      from_cache_rd_req_valid = 1'b0;
      from_cache_rd_req_addr  = $urandom;
    end
    b_count = 0; pend = 1'b0; seen = 1'b0; bp_left = 3;
    hold_errs = 0; rdy_errs = 0; n = 0;
    pd = '0; pl = 1'b0;
    while (b_count < stop_after && n < 400) begin
      if (to_cache_rd_req_ready !== 1'b0) rdy_errs++;
      if (pend && (to_cache_rd_rsp_valid !== 1'b1 || to_cache_rd_rsp_data !== pd ||
                   to_cache_rd_rsp_last !== pl)) hold_errs++;
      if (to_cache_rd_rsp_valid === 1'b1 && !seen) begin
        b_first[b_count] = cyc;
        seen = 1'b1;
      end
      case (bp_mode)
        0: from_cache_rd_rsp_ready = 1'b1;
        1: begin
          if (to_cache_rd_rsp_valid === 1'b1 && b_count == 3 && bp_left > 0) begin
            from_cache_rd_rsp_ready = 1'b0;
            bp_left--;
          end else from_cache_rd_rsp_ready = 1'b1;
        end
        default: from_cache_rd_rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (to_cache_rd_rsp_valid === 1'b1 && from_cache_rd_rsp_ready) begin
        b_data[b_count] = to_cache_rd_rsp_data;
        b_last[b_count] = to_cache_rd_rsp_last;
        b_hs[b_count]   = cyc;
        b_count++;
        seen = 1'b0;
        pend = 1'b0;
      end else begin
        pend = (to_cache_rd_rsp_valid === 1'b1);
        pd   = to_cache_rd_rsp_data;
        pl   = to_cache_rd_rsp_last;
      end
      @(negedge clk);
      n++;
    end
    from_cache_rd_rsp_ready = 1'b0;
    if (b_count < stop_after) begin
      n_total++;
      $display("FAIL burst_timeout: beats=%0d, required %0d", b_count, stop_after);
      ok = 1'b0;
    end
  endtask

  task automatic preload_seq();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      init_wr_en   = 1'b1;
      init_wr_addr = MEM_ADDR_W'(i);
      init_wr_data = 32'h1000_0000 + i;
      model_mem[i] = 32'h1000_0000 + i;
    end
    @(negedge clk);
    init_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    from_cache_rd_req_valid = 1'b0; from_cache_rd_req_addr = '0;
    from_cache_rd_rsp_ready = 1'b0;
    init_wr_en = 1'b0; init_wr_addr = '0; init_wr_data = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({to_cache_rd_req_ready, to_cache_rd_rsp_valid, to_cache_rd_rsp_last} !== 3'b000)
      $display("FAIL reset_ctrl: ready/valid/last=%b, required 000",
               {to_cache_rd_req_ready, to_cache_rd_rsp_valid, to_cache_rd_rsp_last});
    else n_pass++;
    n_total++;
    if (to_cache_rd_rsp_data !== 32'h0)
      $display("FAIL reset_data: got %h, required 00000000", to_cache_rd_rsp_data);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (to_cache_rd_req_ready !== 1'b1)
      $display("FAIL reset_release_ready: got %b, required 1", to_cache_rd_req_ready);
    else n_pass++;
  endtask

  task automatic test_basic_burst(input logic [31:0] addr, input string tag);
    bit ok;
    int gap;
    do_burst(addr, 0, 8, 1'b0, 32'h0, ok);
    if (!ok) return;
    n_total++;
    if (b_first[0] !== t_acc + 1 + RD_LAT)
      $display("FAIL %s_first_beat_cycle: got %0d, required %0d", tag, b_first[0], t_acc + 1 + RD_LAT);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (b_data[i] !== exp_word(addr, i))
        $display("FAIL %s_data[%0d]: got %h, required %h", tag, i, b_data[i], exp_word(addr, i));
      else n_pass++;
      n_total++;
      if (b_last[i] !== (i == 7))
        $display("FAIL %s_last[%0d]: got %b, required %b", tag, i, b_last[i], (i == 7));
      else n_pass++;
    end
    for (int i = 1; i < 8; i++) begin
      gap = b_first[i] - b_hs[i-1] - 1;
      n_total++;
      if (gap < 0 || gap > MAX_GAP)
        $display("FAIL %s_gap[%0d]: got %0d, allowed 0..%0d", tag, i, gap, MAX_GAP);
      else n_pass++;
    end
    n_total++;
    if (hold_errs !== 0 || rdy_errs !== 0)
      $display("FAIL %s_hold_ready: hold_errs=%0d rdy_errs=%0d, required 0/0", tag, hold_errs, rdy_errs);
    else n_pass++;
    n_total++;
    if (cyc !== b_hs[7] + 1 || to_cache_rd_req_ready !== 1'b1 ||
        to_cache_rd_rsp_valid !== 1'b0 || to_cache_rd_rsp_last !== 1'b0)
      $display("FAIL %s_after_last: cycle=%0d ready=%b valid=%b last=%b, required cycle %0d ready=1 valid=0 last=0",
               tag, cyc, to_cache_rd_req_ready, to_cache_rd_rsp_valid, to_cache_rd_rsp_last, b_hs[7] + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    do_burst(32'h0000_0020, 1, 8, 1'b0, 32'h0, ok);
    if (!ok) return;
    n_total++;
    if (b_count !== 8) $display("FAIL bp_count: got %0d, required 8", b_count);
    else n_pass++;
    n_total++;
    if (b_hs[3] - b_first[3] !== 3)
      $display("FAIL bp_beat3_stall: held %0d cycles, required 3", b_hs[3] - b_first[3]);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (b_data[i] !== 32'h1000_0008 + i || b_last[i] !== (i == 7))
        $display("FAIL bp_beat[%0d]: data=%h last=%b, required %h last=%b",
                 i, b_data[i], b_last[i], 32'h1000_0008 + i, (i == 7));
      else n_pass++;
    end
    n_total++;
    if (hold_errs !== 0) $display("FAIL bp_hold: violations=%0d, required 0", hold_errs);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int first_last_cyc;
    do_burst(32'h0000_0020, 0, 8, 1'b1, 32'h0000_0040, ok);
    if (!ok) return;
    n_total++;
    if (rdy_errs !== 0) $display("FAIL b2b_ready_in_burst: count=%0d, required 0", rdy_errs);
    else n_pass++;
    first_last_cyc = b_hs[7];
    do_burst(32'h0000_0040, 0, 8, 1'b0, 32'h0, ok);
    if (!ok) return;
    n_total++;
    if (t_acc !== first_last_cyc + 2)
      $display("FAIL b2b_accept_edge: got %0d, required %0d", t_acc, first_last_cyc + 2);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (b_data[i] !== 32'h1000_0010 + i)
        $display("FAIL b2b_data[%0d]: got %h, required %h", i, b_data[i], 32'h1000_0010 + i);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_burst(32'h0000_0020, 0, 3, 1'b0, 32'h0, ok);
    if (!ok) return;
    rst = 1'b1;
    #1;
    n_total++;
    if ({to_cache_rd_rsp_valid, to_cache_rd_rsp_last, to_cache_rd_req_ready} !== 3'b000 ||
        to_cache_rd_rsp_data !== 32'h0)
      $display("FAIL midrst_clear: valid/last/ready=%b data=%h, required 000 data 00000000",
               {to_cache_rd_rsp_valid, to_cache_rd_rsp_last, to_cache_rd_req_ready}, to_cache_rd_rsp_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (to_cache_rd_req_ready !== 1'b1 || to_cache_rd_rsp_valid !== 1'b0)
      $display("FAIL midrst_release: ready=%b valid=%b, required ready=1 valid=0",
               to_cache_rd_req_ready, to_cache_rd_rsp_valid);
    else n_pass++;
    do_burst(32'h0000_0000, 0, 8, 1'b0, 32'h0, ok);
    if (!ok) return;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (b_data[i] !== 32'h1000_0000 + i)
        $display("FAIL midrst_data[%0d]: got %h, required %h", i, b_data[i], 32'h1000_0000 + i);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit          ok;
    logic [31:0] addr;
    int          line;
    int          gap;
    for (int r = 0; r < 16; r++) begin
      addr = $urandom;
      line = int'((addr / 32) % (DEPTH / 8));
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        init_wr_en   = 1'b1;
        init_wr_addr = MEM_ADDR_W'(line * 8 + i);
        init_wr_data = $urandom;
        model_mem[line * 8 + i] = init_wr_data;
      end
      @(negedge clk);
      init_wr_en = 1'b0;
      do_burst(addr, 2, 8, 1'b0, 32'h0, ok);
      if (!ok) return;
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (b_data[i] !== exp_word(addr, i) || b_last[i] !== (i == 7))
          $display("FAIL rand%0d_beat[%0d]: addr=%h data=%h last=%b, required %h last=%b",
                   r, i, addr, b_data[i], b_last[i], exp_word(addr, i), (i == 7));
        else n_pass++;
      end
      for (int i = 1; i < 8; i++) begin
        gap = b_first[i] - b_hs[i-1] - 1;
        n_total++;
        if (gap < 0 || gap > MAX_GAP)
          $display("FAIL rand%0d_gap[%0d]: got %0d, allowed 0..%0d", r, i, gap, MAX_GAP);
        else n_pass++;
      end
      n_total++;
      if (hold_errs !== 0 || rdy_errs !== 0)
        $display("FAIL rand%0d_hold_ready: hold_errs=%0d rdy_errs=%0d, required 0/0", r, hold_errs, rdy_errs);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    preload_seq();
    test_basic_burst(32'h0000_0020, "basic");
    test_basic_burst(32'h0000_002C, "unaligned");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_basic_burst(32'h0000_1FE0, "alias");
    test_basic_burst(32'hFFFF_F3E4, "alias_high");
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
